rf_access_arbiter: RTL and testbench

Two-master arbiter that shares the single register file between the UART command controller (M0) and a second requester (M1, e.g. a config/scan engine).
- Accepts one read or write request at a time using valid/ready.
- Issues one registered RF strobe per accepted request.
- Routes the RF read data back to the master that issued the read.
- Sits between the masters and the RF, in the RF clock domain.

---
 rtl/rf_arb_pkg.sv | 19 +
 rtl/rf_access_arbiter_if.sv | 56 +++++
 rtl/rr_arb2.sv | 23 ++
 rtl/rf_access_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_rf_access_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file access arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, master id constants, timeout error data pattern.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        RD_WAIT = 2'b10
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Returned as read data when a read times out; truncated to the data width at use.
    localparam logic [63:0] TO_ERR_DATA = '1;

endpackage

// File: rtl/rf_access_arbiter_if.sv
// Bundle of both master request/return channels plus the RF strobe bus.
// Latency: n/a (wires only).
// Backpressure: M*_REQ_RDY is driven by the arbiter side.
// Modports: slave = arbiter view, master = requester/RF-model view.
interface rf_access_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RF_ADDR    = 4
);
    // Master 0
    logic                  M0_REQ_VLD;
    logic                  M0_REQ_WR;
    logic [RF_ADDR-1:0]    M0_ADDR;
    logic [DATA_WIDTH-1:0] M0_WR_DATA;
    logic                  M0_REQ_RDY;
    logic [DATA_WIDTH-1:0] M0_RD_DATA;
    logic                  M0_RD_VLD;
    logic                  M0_RD_ERR;
    // Master 1
    logic                  M1_REQ_VLD;
    logic                  M1_REQ_WR;
    logic [RF_ADDR-1:0]    M1_ADDR;
    logic [DATA_WIDTH-1:0] M1_WR_DATA;
    logic                  M1_REQ_RDY;
    logic [DATA_WIDTH-1:0] M1_RD_DATA;
    logic                  M1_RD_VLD;
    logic                  M1_RD_ERR;
    // Register file
    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [RF_ADDR-1:0]    RF_Address;
    logic [DATA_WIDTH-1:0] RF_WrData;
    logic [DATA_WIDTH-1:0] RF_RdData;
    logic                  RF_RdData_VLD;
    // Status
    logic                  ARB_BUSY;

    modport slave (
        input  M0_REQ_VLD, M0_REQ_WR, M0_ADDR, M0_WR_DATA,
        output M0_REQ_RDY, M0_RD_DATA, M0_RD_VLD, M0_RD_ERR,
        input  M1_REQ_VLD, M1_REQ_WR, M1_ADDR, M1_WR_DATA,
        output M1_REQ_RDY, M1_RD_DATA, M1_RD_VLD, M1_RD_ERR,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        input  RF_RdData, RF_RdData_VLD,
        output ARB_BUSY
    );

    modport master (
        output M0_REQ_VLD, M0_REQ_WR, M0_ADDR, M0_WR_DATA,
        input  M0_REQ_RDY, M0_RD_DATA, M0_RD_VLD, M0_RD_ERR,
        output M1_REQ_VLD, M1_REQ_WR, M1_ADDR, M1_WR_DATA,
        input  M1_REQ_RDY, M1_RD_DATA, M1_RD_VLD, M1_RD_ERR,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        output RF_RdData, RF_RdData_VLD,
        input  ARB_BUSY
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: pointer breaks ties, a lone requester always wins.
// Latency: combinational.
// Backpressure: none; grant is zero when nobody requests.
// Ports: req_i[1:0] request bits, ptr_i preferred master on tie, gnt_o one-hot grant, win_o winner id.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       win_o
);
    always_comb begin
        gnt_o = 2'b00;
        win_o = 1'b0;
        if (req_i == 2'b11) begin
            win_o = ptr_i;
        end else begin
            win_o = req_i[1];
        end
        if (req_i != 2'b00) begin
            gnt_o = win_o ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/rf_access_arbiter.sv
// Shares one register file between two masters; one access in flight at a time.
// Latency: RF strobe 1 cycle after accept; read return 1 cycle after RF_RdData_VLD.
// Backpressure: REQ_RDY only in IDLE for the round-robin winner; all else waits.
// Ports: CLK, RST (sync, active high), bus = rf_access_arbiter_if.slave.
// Optional macro RF_ARB_TIMEOUT_EN: read-wait timeout returning all-ones with RD_ERR.
module rf_access_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int RF_ADDR     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               CLK,
    input  logic               RST,
    rf_access_arbiter_if.slave bus
);
    state_e                state_q;
    logic                  ptr_q;
    logic                  owner_q;
    logic                  busy_q;
    logic                  rf_wr_en_q;
    logic                  rf_rd_en_q;
    logic [RF_ADDR-1:0]    rf_addr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;
    logic                  m0_rd_vld_q, m1_rd_vld_q;
    logic [DATA_WIDTH-1:0] m0_rd_data_q, m1_rd_data_q;
    logic                  m0_rd_err_q, m1_rd_err_q;

    logic [1:0]            req, gnt;
    logic                  win;
    logic                  accept;
    logic                  win_wr;
    logic [RF_ADDR-1:0]    win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  ret;
    logic                  ret_err;
    logic [DATA_WIDTH-1:0] ret_data;

    assign req = {bus.M1_REQ_VLD, bus.M0_REQ_VLD};

    rr_arb2 u_rr_arb2 (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .win_o (win)
    );

    // Ready is only offered while idle so a request arriving mid-access simply waits.
    assign bus.M0_REQ_RDY = (state_q == IDLE) & gnt[0];
    assign bus.M1_REQ_RDY = (state_q == IDLE) & gnt[1];
    assign accept         = (state_q == IDLE) & (|req);

    assign win_wr   = (win == M1) ? bus.M1_REQ_WR   : bus.M0_REQ_WR;
    assign win_addr = (win == M1) ? bus.M1_ADDR     : bus.M0_ADDR;
    assign win_data = (win == M1) ? bus.M1_WR_DATA  : bus.M0_WR_DATA;

`ifdef RF_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    // Read-return decision; real data takes priority over an expiring timer.
    always_comb begin
        ret      = 1'b0;
        ret_err  = 1'b0;
        ret_data = bus.RF_RdData;
        if (state_q == RD_WAIT) begin
            if (bus.RF_RdData_VLD) begin
                ret = 1'b1;
            end
`ifdef RF_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
                ret      = 1'b1;
                ret_err  = 1'b1;
                ret_data = TO_ERR_DATA[DATA_WIDTH-1:0];
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            ptr_q        <= M0;
            owner_q      <= M0;
            busy_q       <= 1'b0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wdata_q   <= '0;
            m0_rd_vld_q  <= 1'b0;
            m1_rd_vld_q  <= 1'b0;
            m0_rd_data_q <= '0;
            m1_rd_data_q <= '0;
            m0_rd_err_q  <= 1'b0;
            m1_rd_err_q  <= 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            m0_rd_vld_q <= 1'b0;
            m1_rd_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q    <= win;
                        ptr_q      <= ~win;
                        rf_wr_en_q <= win_wr;
                        rf_rd_en_q <= ~win_wr;
                        rf_addr_q  <= win_addr;
                        rf_wdata_q <= win_wr ? win_data : '0;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Strobe registers are live for exactly this one cycle.
                    rf_wr_en_q <= 1'b0;
                    rf_rd_en_q <= 1'b0;
                    rf_addr_q  <= '0;
                    rf_wdata_q <= '0;
                    if (rf_rd_en_q) begin
                        state_q <= RD_WAIT;
`ifdef RF_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (ret) begin
                        if (owner_q == M1) begin
                            m1_rd_vld_q  <= 1'b1;
                            m1_rd_data_q <= ret_data;
                            m1_rd_err_q  <= ret_err;
                        end else begin
                            m0_rd_vld_q  <= 1'b1;
                            m0_rd_data_q <= ret_data;
                            m0_rd_err_q  <= ret_err;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`ifdef RF_ARB_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.RF_WrEn    = rf_wr_en_q;
    assign bus.RF_RdEn    = rf_rd_en_q;
    assign bus.RF_Address = rf_addr_q;
    assign bus.RF_WrData  = rf_wdata_q;
    assign bus.ARB_BUSY   = busy_q;
    assign bus.M0_RD_VLD  = m0_rd_vld_q;
    assign bus.M1_RD_VLD  = m1_rd_vld_q;
    assign bus.M0_RD_DATA = m0_rd_data_q;
    assign bus.M1_RD_DATA = m1_rd_data_q;
`ifdef RF_ARB_TIMEOUT_EN
    assign bus.M0_RD_ERR  = m0_rd_err_q;
    assign bus.M1_RD_ERR  = m1_rd_err_q;
`else
    // Error flags only ever set by the timeout path, so they are constant zero here.
    assign bus.M0_RD_ERR  = 1'b0;
    assign bus.M1_RD_ERR  = 1'b0;
    logic unused_err;
    assign unused_err = m0_rd_err_q | m1_rd_err_q;
`endif

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: requests held until REQ_RDY observed.
module tb_rf_access_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    rf_access_arbiter_if #(.DATA_WIDTH(DW), .RF_ADDR(AW)) bus ();

    rf_access_arbiter #(.DATA_WIDTH(DW), .RF_ADDR(AW), .TIMEOUT_CYC(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge CLK);
        #1;
    endtask

    task automatic mid;
        @(negedge CLK);
    endtask

    task automatic clr_inputs;
        bus.M0_REQ_VLD    = 1'b0;
        bus.M0_REQ_WR     = 1'b0;
        bus.M0_ADDR       = '0;
        bus.M0_WR_DATA    = '0;
        bus.M1_REQ_VLD    = 1'b0;
        bus.M1_REQ_WR     = 1'b0;
        bus.M1_ADDR       = '0;
        bus.M1_WR_DATA    = '0;
        bus.RF_RdData     = '0;
        bus.RF_RdData_VLD = 1'b0;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        nxt();
        nxt();
        RST = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        clr_inputs();
        RST = 1'b0;
        nxt();
        do_reset();

        // Reset state
        mid();
        check("rst_busy",  bus.ARB_BUSY, 0);
        check("rst_wren",  bus.RF_WrEn, 0);
        check("rst_rden",  bus.RF_RdEn, 0);
        check("rst_rdy0",  bus.M0_REQ_RDY, 0);
        check("rst_rdy1",  bus.M1_REQ_RDY, 0);
        check("rst_rdvld", {bus.M0_RD_VLD, bus.M1_RD_VLD}, 0);
        nxt();

        // 1: lone M0 write addr 3 data 5A
        bus.M0_REQ_VLD = 1'b1; bus.M0_REQ_WR = 1'b1; bus.M0_ADDR = 4'd3; bus.M0_WR_DATA = 8'h5A;
        mid();
        check("t1_rdy0", bus.M0_REQ_RDY, 1);
        check("t1_rdy1", bus.M1_REQ_RDY, 0);
        check("t1_wren_n", bus.RF_WrEn, 0);
        check("t1_busy_n", bus.ARB_BUSY, 0);
        nxt();
        bus.M0_REQ_VLD = 1'b0;
        mid();
        check("t1_wren", bus.RF_WrEn, 1);
        check("t1_rden", bus.RF_RdEn, 0);
        check("t1_addr", bus.RF_Address, 3);
        check("t1_wdat", bus.RF_WrData, 8'h5A);
        check("t1_busy", bus.ARB_BUSY, 1);
        nxt();
        mid();
        check("t1_wren_n2", bus.RF_WrEn, 0);
        check("t1_addr_n2", bus.RF_Address, 0);
        check("t1_busy_n2", bus.ARB_BUSY, 0);
        nxt();

        // 2: both masters write continuously, grants alternate from M0
        do_reset();
        bus.M0_REQ_VLD = 1'b1; bus.M0_REQ_WR = 1'b1; bus.M0_ADDR = 4'd1; bus.M0_WR_DATA = 8'h11;
        bus.M1_REQ_VLD = 1'b1; bus.M1_REQ_WR = 1'b1; bus.M1_ADDR = 4'd2; bus.M1_WR_DATA = 8'h22;
        for (int g = 0; g < 4; g++) begin
            mid();
            check($sformatf("t2_rdy0_%0d", g), bus.M0_REQ_RDY, (g % 2 == 0) ? 1 : 0);
            check($sformatf("t2_rdy1_%0d", g), bus.M1_REQ_RDY, (g % 2 == 1) ? 1 : 0);
            nxt();
            mid();
            check($sformatf("t2_wren_%0d", g), bus.RF_WrEn, 1);
            check($sformatf("t2_addr_%0d", g), bus.RF_Address, (g % 2 == 0) ? 1 : 2);
            check($sformatf("t2_wdat_%0d", g), bus.RF_WrData, (g % 2 == 0) ? 8'h11 : 8'h22);
            check($sformatf("t2_rdyi_%0d", g), {bus.M0_REQ_RDY, bus.M1_REQ_RDY}, 0);
            nxt();
        end
        clr_inputs();
        nxt();

        // 3: M1 read addr 7, RF answers C3 two cycles after the read strobe
        bus.M1_REQ_VLD = 1'b1; bus.M1_REQ_WR = 1'b0; bus.M1_ADDR = 4'd7;
        mid();
        check("t3_rdy1", bus.M1_REQ_RDY, 1);
        nxt();
        bus.M1_REQ_VLD = 1'b0;
        mid();
        check("t3_rden", bus.RF_RdEn, 1);
        check("t3_wren", bus.RF_WrEn, 0);
        check("t3_addr", bus.RF_Address, 7);
        check("t3_wdat", bus.RF_WrData, 0);
        nxt();
        mid();
        check("t3_rden_w", bus.RF_RdEn, 0);
        check("t3_busy_w", bus.ARB_BUSY, 1);
        nxt();
        bus.RF_RdData = 8'hC3; bus.RF_RdData_VLD = 1'b1;
        mid();
        check("t3_vld_early", bus.M1_RD_VLD, 0);
        nxt();
        bus.RF_RdData_VLD = 1'b0; bus.RF_RdData = 8'h00;
        mid();
        check("t3_vld1", bus.M1_RD_VLD, 1);
        check("t3_dat1", bus.M1_RD_DATA, 8'hC3);
        check("t3_vld0", bus.M0_RD_VLD, 0);
        check("t3_err1", bus.M1_RD_ERR, 0);
        check("t3_busy", bus.ARB_BUSY, 0);
        nxt();
        mid();
        check("t3_vld1_off", bus.M1_RD_VLD, 0);
        check("t3_dat1_hold", bus.M1_RD_DATA, 8'hC3);
        nxt();

        // 6: M0 appears during M1's read wait, then withdraws before being served
        bus.M1_REQ_VLD = 1'b1; bus.M1_REQ_WR = 1'b0; bus.M1_ADDR = 4'd5;
        nxt();
        bus.M1_REQ_VLD = 1'b0;
        nxt();
        bus.M0_REQ_VLD = 1'b1; bus.M0_REQ_WR = 1'b1; bus.M0_ADDR = 4'd9; bus.M0_WR_DATA = 8'h77;
        mid();
        check("t6_rdy0_wait", bus.M0_REQ_RDY, 0);
        check("t6_busy", bus.ARB_BUSY, 1);
        nxt();
        bus.M0_REQ_VLD = 1'b0;
        bus.RF_RdData = 8'h3C; bus.RF_RdData_VLD = 1'b1;
        nxt();
        bus.RF_RdData_VLD = 1'b0;
        mid();
        check("t6_vld1", bus.M1_RD_VLD, 1);
        check("t6_dat1", bus.M1_RD_DATA, 8'h3C);
        check("t6_vld0", bus.M0_RD_VLD, 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.RF_WrEn || bus.RF_RdEn || bus.M0_REQ_RDY) bad++;
            nxt();
            mid();
        end
        check("t6_no_m0_strobe", bad, 0);
        nxt();

        // 5: read with no RF response
        bus.M0_REQ_VLD = 1'b1; bus.M0_REQ_WR = 1'b0; bus.M0_ADDR = 4'd2;
        mid();
        check("t5_rdy0", bus.M0_REQ_RDY, 1);
        nxt();
        bus.M0_REQ_VLD = 1'b0;
        nxt();
`ifdef RF_ARB_TIMEOUT_EN
        n = 0;
        while (bus.M0_RD_VLD !== 1'b1 && n < 40) begin
            n++;
            nxt();
        end
        check("t5_to_cycles", n, TO);
        check("t5_vld0", bus.M0_RD_VLD, 1);
        check("t5_err0", bus.M0_RD_ERR, 1);
        check("t5_dat0", bus.M0_RD_DATA, 8'hFF);
        check("t5_vld1", bus.M1_RD_VLD, 0);
        check("t5_busy", bus.ARB_BUSY, 0);
        nxt();
`else
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.M0_RD_VLD || !bus.ARB_BUSY) bad++;
            nxt();
        end
        check("t5_waits", bad, 0);
        bus.RF_RdData = 8'h81; bus.RF_RdData_VLD = 1'b1;
        nxt();
        bus.RF_RdData_VLD = 1'b0;
        mid();
        check("t5_vld0", bus.M0_RD_VLD, 1);
        check("t5_dat0", bus.M0_RD_DATA, 8'h81);
        check("t5_err0", bus.M0_RD_ERR, 0);
        nxt();
`endif

        // 4a: stray read-data valid while idle
        bus.RF_RdData = 8'hAA; bus.RF_RdData_VLD = 1'b1;
        nxt();
        bus.RF_RdData_VLD = 1'b0;
        mid();
        check("t4_stray_vld", {bus.M0_RD_VLD, bus.M1_RD_VLD}, 0);
        check("t4_stray_busy", bus.ARB_BUSY, 0);
        nxt();

        // 4b: reset during read wait, then a late response
        bus.M0_REQ_VLD = 1'b1; bus.M0_REQ_WR = 1'b0; bus.M0_ADDR = 4'd4;
        nxt();
        bus.M0_REQ_VLD = 1'b0;
        nxt();
        mid();
        check("t4_in_wait", bus.ARB_BUSY, 1);
        nxt();
        RST = 1'b1;
        nxt();
        RST = 1'b0;
        bus.RF_RdData = 8'h55; bus.RF_RdData_VLD = 1'b1;
        mid();
        check("t4_rst_busy", bus.ARB_BUSY, 0);
        check("t4_rst_strobes", {bus.RF_WrEn, bus.RF_RdEn}, 0);
        check("t4_rst_addr", bus.RF_Address, 0);
        check("t4_rst_rddat", {bus.M0_RD_DATA, bus.M1_RD_DATA}, 0);
        check("t4_rst_rdvld", {bus.M0_RD_VLD, bus.M1_RD_VLD}, 0);
        nxt();
        bus.RF_RdData_VLD = 1'b0;
        mid();
        check("t4_late_vld", {bus.M0_RD_VLD, bus.M1_RD_VLD}, 0);
        check("t4_late_err", {bus.M0_RD_ERR, bus.M1_RD_ERR}, 0);
        check("t4_late_busy", bus.ARB_BUSY, 0);
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
